// File: rtl/hazard_forwarding_unit.sv
// Hazard detection and operand forwarding for a 5-stage ARM pipeline.
// Tracks destination info for EX/MEM/WB and drives stall, bubble, flush and bypass selects.
module hazard_forwarding_unit #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [REG_W-1:0] ID_Rn,
    input  logic [REG_W-1:0] ID_Rm,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rd,
    input  logic             ID_RF_enable,
    input  logic             ID_load,
    input  logic             branch_taken,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_flush,
    output logic             CU_MUX_E,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [1:0]       fwd_D,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [REG_W-1:0] PC_REG = {REG_W{1'b1}};

    logic [REG_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic             r_ex_rf_en, r_mem_rf_en, r_wb_rf_en;
    logic             r_ex_load, r_mem_load, r_wb_load;
    logic [CNT_W-1:0] r_stall_count;

    logic [REG_W-1:0] w_src   [3];
    logic             w_use   [3];
    logic             w_match [3];
    logic [1:0]       w_fwd   [3];
    logic             w_hz;

    assign w_src[0] = ID_Rn;
    assign w_src[1] = ID_Rm;
    assign w_src[2] = ID_Rd;
    assign w_use[0] = ID_use_Rn;
    assign w_use[1] = ID_use_Rm;
    assign w_use[2] = ID_use_Rd;

    // Per-source bypass select; EX results from loads are not yet available.
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
        assign w_match[gi] = w_use[gi] && (w_src[gi] == r_ex_rd);

        always_comb begin
            w_fwd[gi] = 2'b00;
            if (Clr || !w_use[gi] || (w_src[gi] == PC_REG))
                w_fwd[gi] = 2'b00;
            else if (r_ex_rf_en && !r_ex_load && (r_ex_rd == w_src[gi]))
                w_fwd[gi] = 2'b01;
            else if (r_mem_rf_en && (r_mem_rd == w_src[gi]))
                w_fwd[gi] = 2'b10;
            else if (r_wb_rf_en && (r_wb_rd == w_src[gi]))
                w_fwd[gi] = 2'b11;
        end
    end

    assign w_hz = !Clr && r_ex_load && r_ex_rf_en &&
                  (w_match[0] || w_match[1] || w_match[2]);

    assign PC_LE       = !w_hz;
    assign IF_ID_LE    = !w_hz;
    assign CU_MUX_E    = w_hz;
    assign IF_ID_flush = !Clr && branch_taken && !w_hz;
    assign fwd_A       = w_fwd[0];
    assign fwd_B       = w_fwd[1];
    assign fwd_D       = w_fwd[2];
    assign stall_count = r_stall_count;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_ex_rd       <= '0;
            r_ex_rf_en    <= 1'b0;
            r_ex_load     <= 1'b0;
            r_mem_rd      <= '0;
            r_mem_rf_en   <= 1'b0;
            r_mem_load    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_rf_en    <= 1'b0;
            r_wb_load     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_wb_rd     <= r_mem_rd;
            r_wb_rf_en  <= r_mem_rf_en;
            r_wb_load   <= r_mem_load;
            r_mem_rd    <= r_ex_rd;
            r_mem_rf_en <= r_ex_rf_en;
            r_mem_load  <= r_ex_load;
            r_ex_rd     <= ID_Rd;
            // A bubble carries no write and no load into EX.
            r_ex_rf_en  <= ID_RF_enable && !w_hz;
            r_ex_load   <= ID_load && !w_hz;
            if (w_hz && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

endmodule
